uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter_pkg.sv | 15 +
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arb_pick.sv | 47 ++++
 rtl/uart_tx_arbiter.sv | 109 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared encodings and widths for the UART TX arbiter slice.
// The optional fixed-priority pick is selected by UART_ARB_FIXED_PRIORITY_EN.
package uart_tx_arbiter_pkg;

    typedef enum logic {
        UART_ARB_IDLE   = 1'b0,
        UART_ARB_LOCKED = 1'b1
    } uart_arb_state_e;

    // Hold counter must reach P_TIMEOUT-1, and P_TIMEOUT is at most 255.
    localparam int UART_ARB_CNT_W = 8;

    localparam string UART_ARB_MACRO_NAME = "UART_ARB_FIXED_PRIORITY_EN";

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the uart TX FIFO write port, bundled for the arbiter.
// master: requesters and FIFO side; slave: the arbiter.
interface uart_tx_arbiter_if #(
    parameter int P_REQ_N   = 4,
    parameter int P_REQ_N_W = 2
);
    logic [P_REQ_N-1:0]   iREQ_VALID;
    logic [P_REQ_N-1:0]   iREQ_LAST;
    logic [8*P_REQ_N-1:0] iREQ_DATA;
    logic [P_REQ_N-1:0]   oREQ_ACK;
    logic [P_REQ_N-1:0]   oGRANT;
    logic [P_REQ_N_W-1:0] oGRANT_ID;
    logic                 oTX_REQ;
    logic [7:0]           oTX_DATA;
    logic                 iTX_BUSY;
    logic                 oTIMEOUT;

    modport master (
        output iREQ_VALID, iREQ_LAST, iREQ_DATA, iTX_BUSY,
        input  oREQ_ACK, oGRANT, oGRANT_ID, oTX_REQ, oTX_DATA, oTIMEOUT
    );

    modport slave (
        input  iREQ_VALID, iREQ_LAST, iREQ_DATA, iTX_BUSY,
        output oREQ_ACK, oGRANT, oGRANT_ID, oTX_REQ, oTX_DATA, oTIMEOUT
    );
endinterface

// File: rtl/uart_tx_arb_pick.sv
// Combinational grant picker: round-robin after last_idx_i, or lowest index when
// UART_ARB_FIXED_PRIORITY_EN is defined.
module uart_tx_arb_pick #(
    parameter int P_REQ_N   = 4,
    parameter int P_REQ_N_W = 2
) (
    input  logic [P_REQ_N-1:0]   valid_i,
    input  logic [P_REQ_N_W-1:0] last_idx_i,
    output logic                 found_o,
    output logic [P_REQ_N_W-1:0] idx_o
);

`ifdef UART_ARB_FIXED_PRIORITY_EN
    logic unused_last_idx;
    assign unused_last_idx = ^last_idx_i;

    always_comb begin
        found_o = |valid_i;
        idx_o   = '0;
        // Scan downward so the lowest valid index is the final winner.
        for (int i = P_REQ_N - 1; i >= 0; i--) begin
            if (valid_i[i]) begin
                idx_o = P_REQ_N_W'(i);
            end
        end
    end
`else
    logic [P_REQ_N_W:0] slot;

    always_comb begin
        found_o = |valid_i;
        idx_o   = '0;
        slot    = '0;
        // Offsets scanned from farthest to nearest so the nearest successor wins.
        for (int i = P_REQ_N; i >= 1; i--) begin
            slot = {1'b0, last_idx_i} + (P_REQ_N_W + 1)'(i);
            if (slot >= (P_REQ_N_W + 1)'(P_REQ_N)) begin
                slot = slot - (P_REQ_N_W + 1)'(P_REQ_N);
            end
            if (valid_i[slot[P_REQ_N_W-1:0]]) begin
                idx_o = slot[P_REQ_N_W-1:0];
            end
        end
    end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Burst-locked arbiter sharing the uart TX FIFO write port among P_REQ_N requesters.
// Define UART_ARB_FIXED_PRIORITY_EN for lowest-index-first instead of round-robin.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int P_REQ_N   = 4,
    parameter int P_REQ_N_W = 2,
    parameter int P_TIMEOUT = 255
) (
    input  logic               iUART_CLOCK,
    input  logic               inRESET,
    input  logic               iARB_EN,
    uart_tx_arbiter_if.slave   arb_if
);

    localparam logic [P_REQ_N_W-1:0]      GRANT_ID_RST = P_REQ_N_W'(P_REQ_N - 1);
    localparam logic [UART_ARB_CNT_W-1:0] HOLD_LAST    = UART_ARB_CNT_W'(P_TIMEOUT - 1);

    uart_arb_state_e           state_q, state_d;
    logic [P_REQ_N_W-1:0]      grant_id_q, grant_id_d;
    logic [UART_ARB_CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic                      pick_found;
    logic [P_REQ_N_W-1:0]      pick_idx;
    logic [7:0]                req_byte [P_REQ_N];
    logic [P_REQ_N-1:0]        owner_onehot;
    logic                      locked;
    logic                      owner_valid;
    logic                      owner_last;
    logic                      accept;
    logic                      hold_expired;

    generate
        for (genvar gi = 0; gi < P_REQ_N; gi++) begin : g_req_byte
            assign req_byte[gi] = arb_if.iREQ_DATA[8*gi +: 8];
        end
    endgenerate

    uart_tx_arb_pick #(
        .P_REQ_N   (P_REQ_N),
        .P_REQ_N_W (P_REQ_N_W)
    ) u_pick (
        .valid_i    (arb_if.iREQ_VALID),
        .last_idx_i (grant_id_q),
        .found_o    (pick_found),
        .idx_o      (pick_idx)
    );

    assign locked       = (state_q == UART_ARB_LOCKED);
    assign owner_onehot = P_REQ_N'(1) << grant_id_q;
    assign owner_valid  = arb_if.iREQ_VALID[grant_id_q];
    assign owner_last   = arb_if.iREQ_LAST[grant_id_q];
    assign accept       = locked && owner_valid && !arb_if.iTX_BUSY;
    // Only a missing byte counts as idle; a stalled FIFO never revokes the grant.
    assign hold_expired = locked && !owner_valid && (hold_cnt_q == HOLD_LAST);

    always_ff @(posedge iUART_CLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q    <= UART_ARB_IDLE;
            grant_id_q <= GRANT_ID_RST;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            UART_ARB_IDLE: begin
                if (iARB_EN && pick_found) begin
                    state_d    = UART_ARB_LOCKED;
                    grant_id_d = pick_idx;
                    hold_cnt_d = '0;
                end
            end
            UART_ARB_LOCKED: begin
                if (accept) begin
                    hold_cnt_d = '0;
                    if (owner_last) begin
                        state_d = UART_ARB_IDLE;
                    end
                end else if (!owner_valid) begin
                    if (hold_expired) begin
                        state_d    = UART_ARB_IDLE;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + UART_ARB_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = UART_ARB_IDLE;
            end
        endcase
    end

    assign arb_if.oGRANT    = locked ? owner_onehot : '0;
    assign arb_if.oGRANT_ID = grant_id_q;
    assign arb_if.oREQ_ACK  = accept ? owner_onehot : '0;
    assign arb_if.oTX_REQ   = accept;
    assign arb_if.oTX_DATA  = locked ? req_byte[grant_id_q] : 8'h00;
    assign arb_if.oTIMEOUT  = hold_expired;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a behavioural owner/idle-count model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 2;
    localparam int TO = 4;

    logic clk    = 1'b0;
    logic nrst   = 1'b0;
    logic arb_en = 1'b0;
    logic [N-1:0]   v    = '0;
    logic [N-1:0]   l    = '0;
    logic [8*N-1:0] d    = '0;
    logic           busy = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.P_REQ_N(N), .P_REQ_N_W(W)) bus ();

    assign bus.iREQ_VALID = v;
    assign bus.iREQ_LAST  = l;
    assign bus.iREQ_DATA  = d;
    assign bus.iTX_BUSY   = busy;

    uart_tx_arbiter #(.P_REQ_N(N), .P_REQ_N_W(W), .P_TIMEOUT(TO)) dut (
        .iUART_CLOCK (clk),
        .inRESET     (nrst),
        .iARB_EN     (arb_en),
        .arb_if      (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: current owner (-1 when none), last owner, idle cycles held.
    int m_owner;
    int m_last;
    int m_idle;

    logic [N-1:0] ack_seen;
    logic [N-1:0] last_grant;
    logic         last_txreq;
    logic         last_to;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int mpick(input logic [N-1:0] vv, input int last);
`ifdef UART_ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < N; i++) if (vv[i]) return i;
`else
        for (int i = 1; i <= N; i++) if (vv[(last + i) % N]) return (last + i) % N;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_idle  = 0;
    endtask

    // Called at a negedge with inputs driven; compares, then advances one cycle.
    task automatic step();
        logic         acc;
        logic [N-1:0] eg;
        logic [7:0]   ed;
        logic         et;
        int           p;
        #1;
        acc = 1'b0; eg = '0; ed = 8'h00; et = 1'b0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ed  = d[8*m_owner +: 8];
            acc = v[m_owner] && !busy;
            et  = !v[m_owner] && (m_idle == TO - 1);
        end
        check_eq("grant",    bus.oGRANT,    eg);
        check_eq("grant_id", bus.oGRANT_ID, m_last);
        check_eq("req_ack",  bus.oREQ_ACK,  acc ? eg : '0);
        check_eq("tx_req",   bus.oTX_REQ,   acc);
        check_eq("tx_data",  bus.oTX_DATA,  ed);
        check_eq("timeout",  bus.oTIMEOUT,  et);
        ack_seen   = bus.oREQ_ACK;
        last_grant = bus.oGRANT;
        last_txreq = bus.oTX_REQ;
        last_to    = bus.oTIMEOUT;
        if (acc) $display("tx owner=%0d data=%02h last=%0b t=%0t", m_owner, ed, l[m_owner], $time);
        if (et)  $display("timeout owner=%0d t=%0t", m_owner, $time);
        @(posedge clk);
        if (m_owner < 0) begin
            p = mpick(v, m_last);
            if (arb_en && p >= 0) begin
                m_owner = p; m_last = p; m_idle = 0;
            end
        end else if (acc) begin
            m_idle = 0;
            if (l[m_owner]) m_owner = -1;
        end else if (!v[m_owner]) begin
            if (m_idle + 1 == TO) begin
                m_owner = -1; m_idle = 0;
            end else begin
                m_idle++;
            end
        end
        @(negedge clk);
    endtask

    task automatic send_byte(input int k, input logic [7:0] b, input logic lst);
        logic done;
        done = 1'b0;
        v[k] = 1'b1; d[8*k +: 8] = b; l[k] = lst;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            done = ack_seen[k];
        end
        check_eq("ack_wait", done, 1'b1);
        v[k] = 1'b0; l[k] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_order [4];
        int got_order [4];
        int got_cyc   [4];
        int n_got;
        int n_to;
        int n_tx;
        logic found;

        model_reset();
        @(negedge clk);
        #1;
        check_eq("rst_grant",    bus.oGRANT,    '0);
        check_eq("rst_grant_id", bus.oGRANT_ID, N - 1);
        check_eq("rst_tx_req",   bus.oTX_REQ,   1'b0);
        check_eq("rst_tx_data",  bus.oTX_DATA,  8'h00);
        check_eq("rst_timeout",  bus.oTIMEOUT,  1'b0);
        @(negedge clk);
        nrst   = 1'b1;
        arb_en = 1'b1;

        // Two-byte burst from req0.
        v[0] = 1'b1; d[7:0] = 8'h41;
        step();
        step();
        check_eq("b1_grant", last_grant, 4'b0001);
        check_eq("b1_tx41",  last_txreq, 1'b1);
        d[7:0] = 8'h42; l[0] = 1'b1;
        step();
        check_eq("b1_tx42",  last_txreq, 1'b1);
        v[0] = 1'b0; l[0] = 1'b0;
        step();
        check_eq("b1_idle",  last_grant, 4'b0000);

        // req1 then req1/req3 continuous single-byte bursts.
        send_byte(1, 8'h11, 1'b1);
`ifdef UART_ARB_FIXED_PRIORITY_EN
        exp_order = '{1, 1, 1, 1};
`else
        exp_order = '{3, 1, 3, 1};
`endif
        v[1] = 1'b1; v[3] = 1'b1; l[1] = 1'b1; l[3] = 1'b1;
        d[15:8] = 8'hA1; d[31:24] = 8'hA3;
        n_got = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            for (int k = 0; k < N; k++) begin
                if (ack_seen[k] && n_got < 4) begin
                    got_order[n_got] = k; got_cyc[n_got] = c; n_got++;
                end
            end
        end
        v = '0; l = '0;
        check_eq("rr_count", n_got, 4);
        for (int i = 0; i < 4; i++) begin
            check_eq("rr_order", got_order[i], exp_order[i]);
            if (i > 0) check_eq("rr_gap", got_cyc[i] - got_cyc[i-1], 2);
        end
        for (int c = 0; c < 8; c++) step();

        // Backpressure: 5 busy cycles never accept and never time out.
        busy = 1'b1; v[0] = 1'b1; d[7:0] = 8'h55; l[0] = 1'b1;
        step();
        n_tx = 0; n_to = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            n_tx += int'(last_txreq); n_to += int'(last_to);
        end
        check_eq("bp_no_tx", n_tx, 0);
        check_eq("bp_no_to", n_to, 0);
        busy = 1'b0;
        step();
        check_eq("bp_accept", ack_seen, 4'b0001);
        v[0] = 1'b0; l[0] = 1'b0;
        step();

        // Timeout after a single non-LAST byte, then req2 takes over.
        send_byte(0, 8'h66, 1'b0);
        v[2] = 1'b1; d[23:16] = 8'h22; l[2] = 1'b1;
        found = 1'b0; n_to = 0;
        for (int c = 1; c <= 12 && !found; c++) begin
            step();
            if (last_to) begin found = 1'b1; n_to = c; end
        end
        check_eq("to_latency", n_to, TO);
        step();
        check_eq("to_released", last_grant, 4'b0000);
        step();
        check_eq("to_next_grant", last_grant, 4'b0100);
        check_eq("to_next_ack",   ack_seen,   4'b0100);
        v[2] = 1'b0; l[2] = 1'b0;
        step();

        // Asynchronous reset in the middle of a 6-byte burst.
        send_byte(0, 8'h01, 1'b0);
        send_byte(0, 8'h02, 1'b0);
        send_byte(0, 8'h03, 1'b0);
        v[0] = 1'b1; d[7:0] = 8'h04;
        #2;
        nrst = 1'b0;
        #1;
        check_eq("arst_tx_req", bus.oTX_REQ,  1'b0);
        check_eq("arst_grant",  bus.oGRANT,   '0);
        check_eq("arst_ack",    bus.oREQ_ACK, '0);
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        step();
        step();
        check_eq("arst_regrant", last_grant, 4'b0001);
        send_byte(0, 8'h05, 1'b1);
        step();

`ifdef UART_ARB_FIXED_PRIORITY_EN
        v[0] = 1'b1; v[2] = 1'b1; l[0] = 1'b1; l[2] = 1'b1;
        n_got = 0; n_tx = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            n_got += int'(ack_seen[0]); n_tx += int'(ack_seen[2]);
        end
        v = '0; l = '0;
        check_eq("fp_req0_grants", n_got, 8);
        check_eq("fp_req2_grants", n_tx, 0);
        for (int c = 0; c < 6; c++) step();
`endif

        // Random traffic; requesters hold valid/data/last until acknowledged.
        for (int c = 0; c < 1200; c++) begin
            arb_en = ($urandom_range(7) != 0);
            busy   = ($urandom_range(3) == 0);
            step();
            for (int k = 0; k < N; k++) begin
                if (ack_seen[k]) begin v[k] = 1'b0; l[k] = 1'b0; end
                if (!v[k] && $urandom_range(2) == 0) begin
                    v[k] = 1'b1;
                    d[8*k +: 8] = 8'($urandom);
                    l[k] = ($urandom_range(2) == 0);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
